// File: rtl/bsg_cache_nb_arb_pkg.sv
// bsg_cache_nb_arb_pkg: cache_nb packet format plus arbiter FSM types and helpers
package bsg_cache_nb_pkg;
  typedef enum logic [5:0] {
    LW     = 6'b000010,
    SW     = 6'b010010,
    TAGST  = 6'b100000,
    TAGFL  = 6'b100001,
    TAGLA  = 6'b100010,
    AFL    = 6'b011000,
    AFLINV = 6'b011001,
    AINV   = 6'b011010
  } bsg_cache_nb_opcode_e;
endpackage

`define DECLARE_BSG_CACHE_NB_PKT_S(addr_width_mp, word_width_mp, src_id_width_mp) \
  typedef struct packed { \
    logic [5:0] opcode; \
    logic [src_id_width_mp-1:0] src_id; \
    logic [addr_width_mp-1:0] addr; \
    logic [word_width_mp-1:0] data; \
    logic [(word_width_mp/8)-1:0] mask; \
  } bsg_cache_nb_pkt_s

`define BSG_CACHE_NB_PKT_WIDTH(addr_width_mp, word_width_mp, src_id_width_mp) \
  (6+(src_id_width_mp)+(addr_width_mp)+(word_width_mp)+((word_width_mp)/8))

package bsg_cache_nb_arb_pkg;
  import bsg_cache_nb_pkg::*;

  typedef enum logic [1:0] {ARB, HOLD, FENCE} arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_tag_fence_op(input logic [5:0] opcode);
    return opcode == TAGST || opcode == TAGFL || opcode == AFLINV;
  endfunction
endpackage

// File: rtl/bsg_cache_nb_arb_rr.sv
// bsg_cache_nb_arb_rr: round-robin picker, first eligible index at or after ptr
module bsg_cache_nb_arb_rr #(
  parameter int num_req_p = 4,
  parameter int lg_req_p  = 2
) (
  input  logic [num_req_p-1:0] eligible,
  input  logic [lg_req_p-1:0]  ptr,
  output logic [num_req_p-1:0] grant,
  output logic [lg_req_p-1:0]  idx,
  output logic                 found
);
  logic [lg_req_p-1:0] j;

  // walking offsets downward lets the closest index to ptr win
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      j = lg_req_p'((int'(ptr) + k) % num_req_p);
      if (eligible[j]) idx = j;
    end
    found = |eligible;
    grant = found ? (num_req_p'(1) << idx) : '0;
  end
endmodule

// File: rtl/bsg_cache_nb_req_arbiter.sv
// bsg_cache_nb_req_arbiter: round-robin share of one cache_nb packet port with per-requester credit limits
module bsg_cache_nb_req_arbiter
  import bsg_cache_nb_arb_pkg::*;
#(
  parameter int num_req_p      = 4,
  parameter int addr_width_p   = 32,
  parameter int word_width_p   = 32,
  parameter int src_id_width_p = 8,
  parameter int max_out_p      = 4,
  localparam int lg_req_lp     = safe_clog2(num_req_p),
  localparam int pkt_w_lp      = `BSG_CACHE_NB_PKT_WIDTH(addr_width_p, word_width_p, src_id_width_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [num_req_p-1:0]          req_v_i,
  input  logic [num_req_p*pkt_w_lp-1:0] req_pkt_i,
  output logic [num_req_p-1:0]          req_yumi_o,
  output logic                          cache_v_o,
  output logic [pkt_w_lp-1:0]           cache_pkt_o,
  input  logic                          cache_yumi_i,
  input  logic                          cache_v_i,
  input  logic [word_width_p-1:0]       cache_data_i,
  input  logic [src_id_width_p:0]       cache_src_id_i,
  output logic                          cache_yumi_o,
  output logic [num_req_p-1:0]          resp_v_o,
  output logic [word_width_p-1:0]       resp_data_o,
  output logic [src_id_width_p:0]       resp_src_id_o,
  input  logic [num_req_p-1:0]          resp_yumi_i
);
  localparam int cnt_w_lp = safe_clog2(max_out_p + 1);

  `DECLARE_BSG_CACHE_NB_PKT_S(addr_width_p, word_width_p, src_id_width_p);

  arb_state_e state, state_n;
  logic [lg_req_lp-1:0] ptr, gidx, ridx;
  logic [num_req_p-1:0] eligible, grant, dec;
  logic found, grant_en;
  logic [cnt_w_lp-1:0] cnt [num_req_p];
  logic [pkt_w_lp-1:0] pkts [num_req_p];
  bsg_cache_nb_pkt_s pkt_r, pkt_n;

  always_comb begin
    eligible = req_v_i;
    for (int i = 0; i < num_req_p; i++) begin
      pkts[i] = req_pkt_i[i*pkt_w_lp +: pkt_w_lp];
      if (cnt[i] >= cnt_w_lp'(max_out_p)) eligible[i] = 1'b0;
    end
  end

  bsg_cache_nb_arb_rr #(
    .num_req_p(num_req_p),
    .lg_req_p (lg_req_lp)
  ) rr (
    .eligible(eligible),
    .ptr     (ptr),
    .grant   (grant),
    .idx     (gidx),
    .found   (found)
  );

  assign grant_en    = reset_n_i && state == ARB && found;
  assign req_yumi_o  = grant_en ? grant : '0;
  assign cache_v_o   = state == HOLD;
  assign cache_pkt_o = pkt_r;

  always_comb begin
    pkt_n = pkts[gidx];
    pkt_n.src_id[src_id_width_p-1 -: lg_req_lp] = gidx;
  end

`ifdef BSG_CACHE_NB_ARB_TAG_FENCE_EN
  logic all_idle;

  always_comb begin
    all_idle = 1'b1;
    for (int i = 0; i < num_req_p; i++) if (cnt[i] != '0) all_idle = 1'b0;
  end

  always_comb begin
    state_n = state;
    state_n = (state == ARB)  ? (found ? HOLD : ARB)
            : (state == HOLD) ? (cache_yumi_i ? (is_tag_fence_op(pkt_r.opcode) ? FENCE : ARB) : HOLD)
            : (all_idle ? ARB : FENCE);
  end
`else
  always_comb begin
    state_n = state;
    state_n = (state == ARB) ? (found ? HOLD : ARB) : (cache_yumi_i ? ARB : HOLD);
  end
`endif

  assign ridx          = cache_src_id_i[src_id_width_p-1 -: lg_req_lp];
  assign resp_v_o      = cache_v_i ? (num_req_p'(1) << ridx) : '0;
  assign cache_yumi_o  = cache_v_i & resp_yumi_i[ridx];
  assign resp_data_o   = cache_data_i;
  assign resp_src_id_o = cache_src_id_i;
  assign dec           = cache_yumi_o ? resp_v_o : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= ARB;
      ptr   <= '0;
      pkt_r <= '0;
      for (int i = 0; i < num_req_p; i++) cnt[i] <= '0;
    end else begin
      state <= state_n;
      if (grant_en) begin
        pkt_r <= pkt_n;
        ptr   <= (gidx == lg_req_lp'(num_req_p - 1)) ? '0 : gidx + lg_req_lp'(1);
      end
      for (int i = 0; i < num_req_p; i++)
        cnt[i] <= cnt[i] + cnt_w_lp'(req_yumi_o[i]) - cnt_w_lp'(dec[i]);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!cache_v_i || int'(ridx) < num_req_p)
        else $fatal(1, "cache response src_id index out of range");
      for (int i = 0; i < num_req_p; i++)
        assert (!dec[i] || cnt[i] != '0)
          else $fatal(1, "outstanding counter underflow");
    end
  end
`endif
endmodule

// File: tb/tb_bsg_cache_nb_req_arbiter.sv
// tb_bsg_cache_nb_req_arbiter: randomized scoreboard bench for the cache_nb request arbiter
module tb_bsg_cache_nb_req_arbiter;
  localparam int N       = 4;
  localparam int AW      = 32;
  localparam int WW      = 32;
  localparam int SW      = 8;
  localparam int MAXO    = 4;
  localparam int LG      = 2;
  localparam int PW      = 6 + SW + AW + WW + WW / 8;
  localparam int SID_LSB = AW + WW + WW / 8;

  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0] req_v, req_yumi, resp_v, resp_yumi;
  logic [N*PW-1:0] req_pkt;
  logic cache_v, cache_yumi, cache_rv, cache_ryumi;
  logic [PW-1:0] cache_pkt;
  logic [WW-1:0] cache_data, resp_data;
  logic [SW:0] cache_src_id, resp_src_id;

  always #5 clk = ~clk;

  bsg_cache_nb_req_arbiter dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .req_v_i       (req_v),
    .req_pkt_i     (req_pkt),
    .req_yumi_o    (req_yumi),
    .cache_v_o     (cache_v),
    .cache_pkt_o   (cache_pkt),
    .cache_yumi_i  (cache_yumi),
    .cache_v_i     (cache_rv),
    .cache_data_i  (cache_data),
    .cache_src_id_i(cache_src_id),
    .cache_yumi_o  (cache_ryumi),
    .resp_v_o      (resp_v),
    .resp_data_o   (resp_data),
    .resp_src_id_o (resp_src_id),
    .resp_yumi_i   (resp_yumi)
  );

  typedef struct packed {
    logic [N-1:0]  v;
    logic [WW-1:0] d;
    logic [SW:0]   id;
    logic          y;
  } rsp_t;

  int checks = 0, passes = 0;

  bit busy = 0, fence = 0;
  int ptr = 0;
  int cnt [N];
  logic [SW-1:0] held_sid;
  logic [5:0] held_op;
  logic [PW-1:0] exp_pkt [$];
  rsp_t exp_rsp [$];
  logic [SW-1:0] pending [$];

  bit d_rst_n = 0, d_cyumi = 0, d_rv = 0, d_flag = 0;
  int d_want = -1;
  logic [N-1:0] d_req_v = '0, d_ryumi = '0;
  logic [PW-1:0] d_pkt [N];
  logic [5:0] ops [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] mk(input logic [5:0] op, input logic [SW-1:0] sid);
    return {op, sid, AW'($urandom), WW'($urandom), 4'($urandom)};
  endfunction

  // one clock: drive knobs, predict from the arbitration rules, check, advance the model
  task automatic step();
    int k, g, ridx;
    bit have, all0;
    logic [SW-1:0] sid;
    logic [WW-1:0] dval;
    logic [N-1:0] eyumi;
    logic [PW-1:0] e;
    rsp_t r;
    @(negedge clk);
    reset_n = d_rst_n;
    req_v = d_req_v;
    for (int i = 0; i < N; i++) req_pkt[i*PW +: PW] = d_pkt[i];
    cache_yumi = d_cyumi;
    resp_yumi = d_ryumi;
    have = 0;
    k = 0;
    sid = '0;
    if (d_rst_n && d_rv && pending.size() > 0) begin
      k = $urandom_range(pending.size() - 1);
      if (d_want >= 0) foreach (pending[j]) if (int'(pending[j] >> (SW - LG)) == d_want) k = j;
      have = 1;
      sid = pending[k];
    end
    dval = $urandom;
    cache_rv = have;
    cache_src_id = {d_flag, sid};
    cache_data = dval;
    #1;
    if (!d_rst_n) begin
      chk("reset_yumi", req_yumi, '0);
      busy = 0;
      fence = 0;
      ptr = 0;
      cnt = '{default: 0};
      exp_pkt.delete();
      exp_rsp.delete();
      pending.delete();
      return;
    end
    chk("cache_v", cache_v, busy);
    all0 = 1;
    foreach (cnt[i]) if (cnt[i] != 0) all0 = 0;
    g = -1;
    if (!busy && !fence)
      for (int o = 0; o < N; o++) begin
        int c;
        c = (ptr + o) % N;
        if (d_req_v[c] && cnt[c] < MAXO) begin
          g = c;
          break;
        end
      end
    eyumi = '0;
    if (g >= 0) eyumi[g] = 1'b1;
    chk("req_yumi", req_yumi, eyumi);
    if (have) begin
      ridx = int'(sid >> (SW - LG));
      r.v = N'(1) << ridx;
      r.d = dval;
      r.id = {d_flag, sid};
      r.y = d_ryumi[ridx];
      exp_rsp.push_back(r);
      if (r.y) begin
        cnt[ridx]--;
        pending.delete(k);
      end
    end
    if (busy && d_cyumi) begin
      pending.push_back(held_sid);
      busy = 0;
`ifdef BSG_CACHE_NB_ARB_TAG_FENCE_EN
      fence = held_op == bsg_cache_nb_pkg::TAGST || held_op == bsg_cache_nb_pkg::TAGFL ||
              held_op == bsg_cache_nb_pkg::AFLINV;
`endif
    end else if (fence && all0) fence = 0;
    if (g >= 0) begin
      e = d_pkt[g];
      e[SID_LSB+SW-LG +: LG] = LG'(g);
      exp_pkt.push_back(e);
      held_sid = e[SID_LSB +: SW];
      held_op = e[PW-1 -: 6];
      cnt[g]++;
      ptr = (g + 1) % N;
      busy = 1;
    end
  endtask

  task automatic drain();
    d_req_v = '0;
    d_cyumi = 1;
    d_rv = 1;
    d_ryumi = '1;
    d_want = -1;
    for (int t = 0; t < 200 && (pending.size() > 0 || busy || fence); t++) step();
    chk("drained", pending.size(), 0);
    d_rv = 0;
  endtask

  // monitor: compares whatever the DUT presents against the queued expectations
  initial forever begin
    rsp_t r;
    @(negedge clk);
    #2;
    if (reset_n === 1'b1) begin
      if (cache_v) begin
        if (exp_pkt.size() == 0) begin
          checks++;
          $display("FAIL pkt_extra: cache_v_o=1 pkt=%h with nothing expected", cache_pkt);
        end else begin
          chk("cache_pkt", cache_pkt, exp_pkt[0]);
          if (cache_yumi) void'(exp_pkt.pop_front());
        end
      end
      if (|resp_v || exp_rsp.size() > 0) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          $display("FAIL rsp_extra: resp_v_o=%b with nothing expected", resp_v);
        end else begin
          r = exp_rsp.pop_front();
          chk("resp_v", resp_v, r.v);
          chk("resp_data", resp_data, r.d);
          chk("resp_src_id", resp_src_id, r.id);
          chk("cache_yumi_o", cache_ryumi, r.y);
        end
      end
    end
  end

  initial begin
    ops = '{bsg_cache_nb_pkg::LW, bsg_cache_nb_pkg::SW, bsg_cache_nb_pkg::TAGST,
            bsg_cache_nb_pkg::TAGFL, bsg_cache_nb_pkg::AFLINV, bsg_cache_nb_pkg::AFL};
    cnt = '{default: 0};
    reset_n = 0;
    req_v = '0;
    req_pkt = '0;
    cache_yumi = 0;
    cache_rv = 0;
    cache_data = '0;
    cache_src_id = '0;
    resp_yumi = '0;
    d_rst_n = 0;
    d_req_v = '1;
    for (int i = 0; i < N; i++) d_pkt[i] = mk(bsg_cache_nb_pkg::LW, SW'(i));
    step();
    step();
    d_rst_n = 1;
    d_req_v = '0;
    step();
    chk("reset_pkt", cache_pkt, '0);

    d_req_v = 4'b0100;
    d_pkt[2] = mk(bsg_cache_nb_pkg::LW, 8'h05);
    step();
    d_req_v = '0;
    d_cyumi = 1;
    step();
    chk("single_sid", cache_pkt[SID_LSB +: SW], 8'h85);

    d_req_v = '1;
    for (int i = 0; i < N; i++) d_pkt[i] = mk(bsg_cache_nb_pkg::SW, 8'($urandom));
    repeat (10) step();
    drain();

    d_req_v = 4'b0010;
    d_cyumi = 1;
    repeat (10) step();
    d_req_v = 4'b0011;
    repeat (4) step();
    d_want = 1;
    d_rv = 1;
    d_ryumi = 4'b0010;
    step();
    d_rv = 0;
    d_want = -1;
    d_req_v = 4'b0010;
    repeat (3) step();
    drain();

    d_req_v = '1;
    d_cyumi = 0;
    repeat (6) step();
    d_cyumi = 1;
    repeat (2) step();
    drain();

    d_req_v = 4'b1000;
    d_pkt[3] = mk(bsg_cache_nb_pkg::LW, 8'h03);
    step();
    d_req_v = '0;
    repeat (2) step();
    d_rv = 1;
    d_want = 3;
    d_flag = 1;
    d_ryumi = 4'b0000;
    step();
    chk("route_v", resp_v, 4'b1000);
    chk("route_id", resp_src_id, 9'h1C3);
    chk("route_noyumi", cache_ryumi, 1'b0);
    d_ryumi = 4'b1000;
    step();
    chk("route_yumi", cache_ryumi, 1'b1);
    d_rv = 0;
    d_want = -1;
    d_flag = 0;

    d_req_v = '1;
    d_cyumi = 0;
    repeat (2) step();
    d_rst_n = 0;
    step();
    d_rst_n = 1;
    d_req_v = '0;
    step();
    chk("midreset_pkt", cache_pkt, '0);

    repeat (3000) begin
      d_rst_n = $urandom_range(499) != 0;
      d_req_v = N'($urandom);
      for (int i = 0; i < N; i++) d_pkt[i] = mk(ops[$urandom_range(5)], 8'($urandom));
      d_cyumi = $urandom_range(3) != 0;
      d_rv = $urandom_range(1) != 0;
      d_ryumi = N'($urandom);
      d_flag = $urandom_range(1) != 0;
      step();
    end
    d_rst_n = 1;
    drain();
    step();
    chk("pkt_queue_empty", exp_pkt.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
